// File: rtl/stage_sequencer_if.sv
// Memory request/ack handshakes between the stage sequencer and instruction/data memories.
// Latency: wires only; no storage.
// Backpressure: requests are held until the matching ack; acks have no ready return path.
interface stage_sequencer_if;
    logic imem_req_o;
    logic imem_ack_i;
    logic dmem_req_o;
    logic dmem_we_o;
    logic dmem_ack_i;

    // Sequencer side: issues requests, receives acks
    modport master (
        output imem_req_o,
        output dmem_req_o,
        output dmem_we_o,
        input  imem_ack_i,
        input  dmem_ack_i
    );

    // Memory side: receives requests, returns acks
    modport slave (
        input  imem_req_o,
        input  dmem_req_o,
        input  dmem_we_o,
        output imem_ack_i,
        output dmem_ack_i
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM with per-stage strobes and retire counter.
// Latency: FETCH and MEMORY take one cycle plus ack wait; other stages are exactly one cycle.
// Backpressure: requests are held until ack; STAGE_SEQ_TIMEOUT_EN bounds each wait and faults to HALT.
module stage_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_i,
    input  logic [31:0]          ir_i,
    stage_sequencer_if.master    bus,
    output logic [2:0]           stage_o,
    output logic                 ir_load_o,
    output logic                 readin_a_o,
    output logic                 readin_b_o,
    output logic                 readin_pass_o,
    output logic                 rf_we_o,
    output logic                 retire_o,
    output logic [CNT_W-1:0]     instret_o,
    output logic                 halt_o,
    output logic                 fault_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6,
        BAD       = 3'd7
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // A zero timeout would fault before any memory could answer
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("stage_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             imem_req, dmem_req, dmem_we;
    logic             is_store;
    logic [19:0]      ir_unused;

    // Only opcode and rd are consumed here; the rest of the IR belongs to decode
    assign ir_unused = ir_i[31:12];
    assign is_store  = (ir_i[6:0] == OP_STORE);

`ifdef STAGE_SEQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              fault_q, fault_d;
    logic              waiting, acked;

    assign waiting = (state_q == FETCH) || (state_q == MEMORY);
    assign acked   = ((state_q == FETCH) && bus.imem_ack_i) || ((state_q == MEMORY) && bus.dmem_ack_i);

    // Wait counter is zero outside FETCH/MEMORY and after any ack, so every wait starts fresh
    always_comb begin
        wait_cnt_d = '0;
        fault_d    = fault_q;
        if (waiting && !acked) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_q == WAIT_LAST) begin
                fault_d = 1'b1;
            end
        end
    end

    // Timeout state: wait counter and sticky fault flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    assign fault_o = fault_q;
`else
    assign fault_o = 1'b0;
`endif

    // Next-state and combinational strobes decoded from state, opcode and acks
    always_comb begin
        state_d       = state_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_load_o     = 1'b0;
        readin_a_o    = 1'b0;
        readin_b_o    = 1'b0;
        readin_pass_o = 1'b0;
        rf_we_o       = 1'b0;
        retire_o      = 1'b0;
        halt_o        = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_i) state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ack_i) begin
                    ir_load_o = 1'b1;
                    state_d   = DECODE;
                end
`ifdef STAGE_SEQ_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = HALT;
                end
`endif
            end
            DECODE: begin
                readin_a_o    = 1'b1;
                readin_b_o    = 1'b1;
                readin_pass_o = 1'b1;
                state_d       = EXECUTE;
            end
            EXECUTE: begin
                case (ir_i[6:0])
                    OP_LOAD, OP_STORE: state_d = MEMORY;
                    OP_SYSTEM: begin
                        retire_o = 1'b1;
                        state_d  = HALT;
                    end
                    OP_BRANCH: begin
                        retire_o = 1'b1;
                        state_d  = run_i ? FETCH : IDLE;
                    end
                    default: state_d = WRITEBACK;
                endcase
            end
            MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (bus.dmem_ack_i) begin
                    if (is_store) begin
                        retire_o = 1'b1;
                        state_d  = run_i ? FETCH : IDLE;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end
`ifdef STAGE_SEQ_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = HALT;
                end
`endif
            end
            WRITEBACK: begin
                rf_we_o  = (ir_i[11:7] != 5'd0);
                retire_o = 1'b1;
                state_d  = run_i ? FETCH : IDLE;
            end
            HALT: begin
                halt_o = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign instret_d = instret_q + CNT_W'(retire_o);

    // State register and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign bus.imem_req_o = imem_req;
    assign bus.dmem_req_o = dmem_req;
    assign bus.dmem_we_o  = dmem_we;
    assign stage_o        = state_q;
    assign instret_o      = instret_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with a per-cycle expectation scoreboard.
// Latency: expectations are checked 1 time unit after each falling edge.
// Backpressure: memory acks are scripted per cycle in the scoreboard entries.
module tb_stage_sequencer;

`ifdef STAGE_SEQ_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        run_i;
    logic [31:0] ir_i;
    logic [2:0]  stage_o;
    logic        ir_load_o, readin_a_o, readin_b_o, readin_pass_o;
    logic        rf_we_o, retire_o, halt_o, fault_o;
    logic [31:0] instret_o;

    stage_sequencer_if bus();

    stage_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .run_i         (run_i),
        .ir_i          (ir_i),
        .bus           (bus),
        .stage_o       (stage_o),
        .ir_load_o     (ir_load_o),
        .readin_a_o    (readin_a_o),
        .readin_b_o    (readin_b_o),
        .readin_pass_o (readin_pass_o),
        .rf_we_o       (rf_we_o),
        .retire_o      (retire_o),
        .instret_o     (instret_o),
        .halt_o        (halt_o),
        .fault_o       (fault_o)
    );

    always #5 clk = ~clk;

    // Strobe vector bit positions
    localparam int B_IMR = 10, B_IRL = 9, B_RA = 8, B_RB = 7, B_RP = 6;
    localparam int B_DMR = 5, B_DWE = 4, B_RFW = 3, B_RET = 2, B_HLT = 1, B_FLT = 0;

    typedef struct {
        logic [2:0]  stage;
        logic [10:0] strb;
        logic [31:0] instret;
        logic        run;
        logic [31:0] ir;
        logic        ack_i;
        logic        ack_d;
    } item_t;

    item_t       sb[$];
    int unsigned m_instret;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [4:0] rd);
        return {20'h00000, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue one expected cycle; a retiring cycle bumps the model counter for later cycles
    task automatic push(input logic [2:0] stage, input logic [10:0] strb, input logic run,
                        input logic [31:0] ir, input logic ack_i, input logic ack_d);
        item_t e;
        e.stage   = stage;
        e.strb    = strb;
        e.instret = m_instret;
        e.run     = run;
        e.ir      = ir;
        e.ack_i   = ack_i;
        e.ack_d   = ack_d;
        sb.push_back(e);
        if (strb[B_RET]) m_instret++;
    endtask

    // Expected trace of one instruction starting in FETCH
    task automatic plan(input logic [31:0] ir, input int iw, input int dw, input logic run);
        logic [6:0]  op;
        logic [10:0] s;
        logic        ld, st;
        op = ir[6:0];
        ld = (op == 7'h03);
        st = (op == 7'h23);
        for (int i = 0; i < iw; i++) begin
            s = '0; s[B_IMR] = 1'b1;
            push(3'd1, s, run, ir, 1'b0, 1'b0);
        end
        s = '0; s[B_IMR] = 1'b1; s[B_IRL] = 1'b1;
        push(3'd1, s, run, ir, 1'b1, 1'b0);
        s = '0; s[B_RA] = 1'b1; s[B_RB] = 1'b1; s[B_RP] = 1'b1;
        push(3'd2, s, run, ir, 1'b0, 1'b0);
        s = '0;
        if (op == 7'h73 || op == 7'h63) s[B_RET] = 1'b1;
        push(3'd3, s, run, ir, 1'b0, 1'b0);
        if (ld || st) begin
            for (int j = 0; j < dw; j++) begin
                s = '0; s[B_DMR] = 1'b1; s[B_DWE] = st;
                push(3'd4, s, run, ir, 1'b0, 1'b0);
            end
            s = '0; s[B_DMR] = 1'b1; s[B_DWE] = st; s[B_RET] = st;
            push(3'd4, s, run, ir, 1'b0, 1'b1);
        end
        if (!st && op != 7'h63 && op != 7'h73) begin
            s = '0; s[B_RFW] = (ir[11:7] != 5'd0); s[B_RET] = 1'b1;
            push(3'd5, s, run, ir, 1'b0, 1'b0);
        end
    endtask

    function automatic logic [10:0] obs_strb();
        return {bus.imem_req_o, ir_load_o, readin_a_o, readin_b_o, readin_pass_o,
                bus.dmem_req_o, bus.dmem_we_o, rf_we_o, retire_o, halt_o, fault_o};
    endfunction

    // Drain the scoreboard one cycle per entry, comparing just after each falling edge
    task automatic run_queue();
        item_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            run_i          = e.run;
            ir_i           = e.ir;
            bus.imem_ack_i = e.ack_i;
            bus.dmem_ack_i = e.ack_d;
            #1;
            chk($sformatf("stage@%0t", $time), 32'(stage_o), 32'(e.stage));
            chk($sformatf("strobes@%0t", $time), 32'(obs_strb()), 32'(e.strb));
            chk($sformatf("instret@%0t", $time), instret_o, e.instret);
            @(negedge clk);
        end
        bus.imem_ack_i = 1'b0;
        bus.dmem_ack_i = 1'b0;
    endtask

    initial begin
        logic [10:0] s;
        reset = 1'b1;
        run_i = 1'b0;
        ir_i  = 32'h0;
        bus.imem_ack_i = 1'b0;
        bus.dmem_ack_i = 1'b0;
        m_instret = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_stage", 32'(stage_o), 32'd0);
        chk("reset_strobes", 32'(obs_strb()), 32'd0);
        chk("reset_instret", instret_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back instructions, then run dropped at boundaries and mid-instruction
        push(3'd0, 11'd0, 1'b1, 32'h0, 1'b0, 1'b0);
        plan(mk_ir(7'h13, 5'd5), 0, 0, 1'b1);
        plan(mk_ir(7'h03, 5'd3), 1, 3, 1'b1);
        plan(mk_ir(7'h23, 5'd9), 0, 1, 1'b1);
        plan(mk_ir(7'h63, 5'd0), 2, 0, 1'b1);
        plan(mk_ir(7'h13, 5'd0), 0, 0, 1'b0);
        push(3'd0, 11'd0, 1'b0, 32'h0, 1'b1, 1'b1);
        push(3'd0, 11'd0, 1'b1, 32'h0, 1'b0, 1'b0);
        plan(mk_ir(7'h03, 5'd7), 0, 1, 1'b0);
        push(3'd0, 11'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        push(3'd0, 11'd0, 1'b1, 32'h0, 1'b0, 1'b0);
        plan(32'h00100073, 0, 0, 1'b1);
        s = '0; s[B_HLT] = 1'b1;
        for (int k = 0; k < 4; k++) push(3'd6, s, k[0], 32'h00100073, ~k[0], k[0]);
        run_queue();

        // Reset out of HALT
        reset = 1'b1;
        #1;
        chk("halt_reset_stage", 32'(stage_o), 32'd0);
        chk("halt_reset_instret", instret_o, 32'd0);
        chk("halt_reset_strobes", 32'(obs_strb()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_instret = 0;

        // Reset mid-MEMORY: request drops without waiting for an edge
        push(3'd0, 11'd0, 1'b1, 32'h0, 1'b0, 1'b0);
        plan(mk_ir(7'h03, 5'd4), 0, 5, 1'b1);
        while (sb.size() > 6) void'(sb.pop_back());
        run_queue();
        #1;
        chk("mem_wait_stage", 32'(stage_o), 32'd4);
        chk("mem_wait_req", 32'(bus.dmem_req_o), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midmem_reset_stage", 32'(stage_o), 32'd0);
        chk("midmem_reset_req", 32'(bus.dmem_req_o), 32'd0);
        chk("midmem_reset_instret", instret_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_instret = 0;

`ifdef STAGE_SEQ_TIMEOUT_EN
        // Ack on the limit cycle wins; then a silent fetch faults into HALT
        push(3'd0, 11'd0, 1'b1, 32'h0, 1'b0, 1'b0);
        plan(mk_ir(7'h13, 5'd1), TO - 1, 0, 1'b1);
        s = '0; s[B_IMR] = 1'b1;
        for (int k = 0; k < int'(TO); k++) push(3'd1, s, 1'b1, 32'h0, 1'b0, 1'b0);
        s = '0; s[B_HLT] = 1'b1; s[B_FLT] = 1'b1;
        push(3'd6, s, 1'b1, 32'h0, 1'b1, 1'b0);
        push(3'd6, s, 1'b0, 32'h0, 1'b0, 1'b0);
        run_queue();
        reset = 1'b1;
        #1;
        chk("fault_reset_fault", 32'(fault_o), 32'd0);
        chk("fault_reset_stage", 32'(stage_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
